// File: rtl/add_arbiter_pkg.sv
// Types, constants and helpers shared by add_arbiter and its sub-modules.
`include "add_arb_defs.vh"

package add_arbiter_pkg;
  localparam int DATA_W  = `DATA_W;
  localparam int ID_W    = `ID_W;
  localparam int MAX_REQ = `MAX_REQ;

  typedef enum logic {
    ST_EMPTY = `ST_EMPTY,
    ST_FULL  = `ST_FULL
  } state_e;

  // Round-robin pointer advance, wrapping at the configured requester count.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx, input int nreq);
    if (int'(idx) >= nreq - 1) return '0;
    return idx + 1'b1;
  endfunction
endpackage

// File: rtl/add_arb_defs.vh
// Shared widths and FSM state encodings for the add_arbiter slice.
`ifndef ADD_ARB_DEFS_VH
`define ADD_ARB_DEFS_VH
`define DATA_W   32
`define ID_W     2
`define MAX_REQ  4
`define ST_EMPTY 1'b0
`define ST_FULL  1'b1
`endif

// File: rtl/carryselect32.sv
// 32-bit carry-select adder: each 8-bit block precomputes sums for both
// carry values (c_0 / c_1) and the incoming block carry picks one.
module carryselect32
  import add_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_0,
  input  logic              c_1,
  input  logic              ci,
  output logic [DATA_W-1:0] sum,
  output logic              co
);
  localparam int BLK  = 8;
  localparam int NBLK = DATA_W / BLK;

  logic [NBLK:0] carry;
  assign carry[0] = ci;

  for (genvar gi = 0; gi < NBLK; gi++) begin : gen_blk
    logic [BLK:0] s0;
    logic [BLK:0] s1;
    assign s0 = {1'b0, a[gi*BLK +: BLK]} + {1'b0, b[gi*BLK +: BLK]} + {{BLK{1'b0}}, c_0};
    assign s1 = {1'b0, a[gi*BLK +: BLK]} + {1'b0, b[gi*BLK +: BLK]} + {{BLK{1'b0}}, c_1};
    assign sum[gi*BLK +: BLK] = carry[gi] ? s1[BLK-1:0] : s0[BLK-1:0];
    assign carry[gi+1]        = carry[gi] ? s1[BLK] : s0[BLK];
  end

  assign co = carry[NBLK];
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr wins.
module rr_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx
);
  localparam logic [2:0] NREQ_3 = 3'(NREQ);

  logic [2:0] cand;
  logic       found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + 3'(k);
      if (cand >= NREQ_3) cand = cand - NREQ_3;
      if (enable && !found && req[cand[ID_W-1:0]]) begin
        found                   = 1'b1;
        grant[cand[ID_W-1:0]]   = 1'b1;
        grant_idx               = cand[ID_W-1:0];
      end
    end
  end
endmodule

// File: rtl/add_arbiter.sv
// Shared 32-bit adder serving NREQ requesters round-robin into one result register.
// Define ADD_ARB_OVF_EN to add the registered signed-overflow output rsp_ovf.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  output logic [NREQ-1:0]        ack,
  input  logic [DATA_W*NREQ-1:0] a_in,
  input  logic [DATA_W*NREQ-1:0] b_in,
  input  logic [NREQ-1:0]        ci_in,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_sum,
  output logic                   rsp_co,
  output logic [ID_W-1:0]        rsp_id
`ifdef ADD_ARB_OVF_EN
  ,
  output logic                   rsp_ovf
`endif
);
  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              co_q, co_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic              grant_en;
  logic              granted;
  logic [ID_W-1:0]   gnt_idx;
  logic [DATA_W-1:0] a_arr [NREQ];
  logic [DATA_W-1:0] b_arr [NREQ];
  logic [DATA_W-1:0] add_sum;
  logic              add_co;

  for (genvar gi = 0; gi < NREQ; gi++) begin : gen_unpack
    assign a_arr[gi] = a_in[gi*DATA_W +: DATA_W];
    assign b_arr[gi] = b_in[gi*DATA_W +: DATA_W];
  end

  // A held result blocks new grants unless it is being consumed this cycle.
  assign grant_en = !rst && ((state_q == ST_EMPTY) || rsp_ready);

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req),
    .ptr       (ptr_q),
    .enable    (grant_en),
    .grant     (ack),
    .grant_idx (gnt_idx)
  );

  assign granted = |ack;

  carryselect32 u_add (
    .a   (a_arr[gnt_idx]),
    .b   (b_arr[gnt_idx]),
    .c_0 (1'b0),
    .c_1 (1'b1),
    .ci  (ci_in[gnt_idx]),
    .sum (add_sum),
    .co  (add_co)
  );

`ifdef ADD_ARB_OVF_EN
  logic ovf_q, ovf_d;
  logic add_ovf;
  assign add_ovf = (a_arr[gnt_idx][DATA_W-1] == b_arr[gnt_idx][DATA_W-1]) &&
                   (add_sum[DATA_W-1] != a_arr[gnt_idx][DATA_W-1]);
  assign rsp_ovf = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    co_d    = co_q;
    id_d    = id_q;
`ifdef ADD_ARB_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (granted) begin
      state_d = ST_FULL;
      ptr_d   = next_ptr(gnt_idx, NREQ);
      sum_d   = add_sum;
      co_d    = add_co;
      id_d    = gnt_idx;
`ifdef ADD_ARB_OVF_EN
      ovf_d   = add_ovf;
`endif
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      id_q    <= '0;
`ifdef ADD_ARB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      id_q    <= id_d;
`ifdef ADD_ARB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_sum   = sum_q;
  assign rsp_co    = co_q;
  assign rsp_id    = id_q;
endmodule

// File: tb/tb_add_arbiter.sv
// Directed scoreboard bench for add_arbiter: grants push expected results,
// held/consumed results are compared against the queue head.
module tb_add_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [3:0]   ack;
  logic [127:0] a_in;
  logic [127:0] b_in;
  logic [3:0]   ci_in;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_sum;
  logic         rsp_co;
  logic [1:0]   rsp_id;
`ifdef ADD_ARB_OVF_EN
  logic         rsp_ovf;
`endif

  always #5 clk = ~clk;

  add_arbiter #(.NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .a_in      (a_in),
    .b_in      (b_in),
    .ci_in     (ci_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_co    (rsp_co),
    .rsp_id    (rsp_id)
`ifdef ADD_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        co;
    logic [1:0]  id;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic ci);
    a_in[i*32 +: 32] = a;
    b_in[i*32 +: 32] = b;
    ci_in[i]         = ci;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "/ack"},   33'(ack), 33'd0);
    chk({tag, "/valid"}, 33'(rsp_valid), 33'd0);
    chk({tag, "/sum"},   33'(rsp_sum), 33'd0);
    chk({tag, "/co"},    33'(rsp_co), 33'd0);
    chk({tag, "/id"},    33'(rsp_id), 33'd0);
`ifdef ADD_ARB_OVF_EN
    chk({tag, "/ovf"},   33'(rsp_ovf), 33'd0);
`endif
  endtask

  // One clock cycle: entered just after a negedge with inputs already driven.
  task automatic tick(input logic [3:0] exp_ack, input string tag);
    exp_t        e;
    logic [32:0] full;
    logic [31:0] a;
    logic [31:0] b;
    int          idx;
    #1;
    chk({tag, "/ack"},   33'(ack), 33'(exp_ack));
    chk({tag, "/valid"}, 33'(rsp_valid), 33'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk({tag, "/sum"}, 33'(rsp_sum), 33'(sb[0].sum));
      chk({tag, "/co"},  33'(rsp_co),  33'(sb[0].co));
      chk({tag, "/id"},  33'(rsp_id),  33'(sb[0].id));
`ifdef ADD_ARB_OVF_EN
      chk({tag, "/ovf"}, 33'(rsp_ovf), 33'(sb[0].ovf));
`endif
    end
    idx = 0;
    for (int i = 0; i < 4; i++) if (exp_ack[i]) idx = i;
    a      = a_in[idx*32 +: 32];
    b      = b_in[idx*32 +: 32];
    full   = {1'b0, a} + {1'b0, b} + 33'(ci_in[idx]);
    e.sum  = full[31:0];
    e.co   = full[32];
    e.id   = 2'(idx);
    e.ovf  = (a[31] == b[31]) && (full[31] != a[31]);
    @(posedge clk);
    if (rst) begin
      sb.delete();
    end else begin
      if (rsp_ready && sb.size() != 0) void'(sb.pop_front());
      if (exp_ack != 4'b0) sb.push_back(e);
    end
    @(negedge clk);
    req = req & ~exp_ack;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; rsp_ready = 1'b1;
    a_in = '0; b_in = '0; ci_in = '0;
    @(negedge clk);
    req = 4'b0001;
    tick(4'b0000, "rst_hold");
    reset_check("rst");

    // Single requester, first cycle after reset.
    rst = 1'b0;
    set_op(0, 32'd5, 32'd10, 1'b1);
    tick(4'b0001, "single_grant");
    chk("single_sum_const", 33'(rsp_sum), 33'd16);
    tick(4'b0000, "single_rsp");
    tick(4'b0000, "single_idle");

    // All four requesters back to back after a fresh reset.
    rst = 1'b1;
    tick(4'b0000, "rst2");
    reset_check("rst2");
    rst = 1'b0;
    set_op(0, 32'd37,  32'd48,  1'b0);
    set_op(1, 32'd125, 32'd110, 1'b1);
    set_op(2, 32'd63,  32'd211, 1'b0);
    set_op(3, 32'd122, 32'd11,  1'b1);
    req = 4'b1111;
    tick(4'b0001, "rr_g0");
    chk("rr_sum0_const", 33'(rsp_sum), 33'd85);
    tick(4'b0010, "rr_g1");
    chk("rr_sum1_const", 33'(rsp_sum), 33'd236);
    tick(4'b0100, "rr_g2");
    chk("rr_sum2_const", 33'(rsp_sum), 33'd274);
    tick(4'b1000, "rr_g3");
    chk("rr_sum3_const", 33'(rsp_sum), 33'd134);
    tick(4'b0000, "rr_drain");
    tick(4'b0000, "rr_idle");

    // Backpressure: result held, pending req[2] not acked until ready.
    set_op(0, 32'd1000, 32'd234, 1'b0);
    req = 4'b0001;
    tick(4'b0001, "bp_fill");
    rsp_ready = 1'b0;
    set_op(2, 32'd7, 32'd8, 1'b1);
    req = 4'b0100;
    tick(4'b0000, "bp_hold0");
    tick(4'b0000, "bp_hold1");
    tick(4'b0000, "bp_hold2");
    chk("bp_sum_const", 33'(rsp_sum), 33'd1234);
    rsp_ready = 1'b1;
    tick(4'b0100, "bp_resume");
    tick(4'b0000, "bp_out");

    // Carry-out and signed overflow corners.
    set_op(3, 32'hFFFF_FFFF, 32'd1, 1'b0);
    req = 4'b1000;
    tick(4'b1000, "wrap_grant");
    chk("wrap_sum_const", 33'(rsp_sum), 33'd0);
    chk("wrap_co_const",  33'(rsp_co),  33'd1);
    tick(4'b0000, "wrap_out");
    set_op(0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    req = 4'b0001;
    tick(4'b0001, "ovf_grant");
    chk("ovf_sum_const", 33'(rsp_sum), 33'h0_8000_0000);
    chk("ovf_co_const",  33'(rsp_co),  33'd0);
`ifdef ADD_ARB_OVF_EN
    chk("ovf_flag_const", 33'(rsp_ovf), 33'd1);
`endif
    tick(4'b0000, "ovf_out");

    // Reset while FULL with req[1] pending discards the held result.
    set_op(1, 32'd3, 32'd4, 1'b0);
    req = 4'b0010;
    tick(4'b0010, "rf_fill");
    rsp_ready = 1'b0;
    set_op(1, 32'd20, 32'd22, 1'b0);
    req = 4'b0010;
    tick(4'b0000, "rf_pend");
    rst = 1'b1;
    tick(4'b0000, "rf_rst");
    reset_check("rf_after");
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick(4'b0010, "rf_regrant");
    chk("rf_sum_const", 33'(rsp_sum), 33'd42);
    chk("rf_id_const",  33'(rsp_id),  33'd1);
    tick(4'b0000, "rf_out");
    tick(4'b0000, "rf_idle");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters; legal 2..4; ID width fixed at 2 bits.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  NREQ  per-requester add request, level, held until ack.
REQ-005 Port: ack  output  NREQ  one-hot, one-cycle grant pulse; operands consumed that cycle.
REQ-006 Port: a_in  input  32*NREQ  operand A, requester i at bits [32i+31:32i].
REQ-007 Port: b_in  input  32*NREQ  operand B, same packing.
REQ-008 Port: ci_in  input  NREQ  carry-in per requester.
REQ-009 Port: rsp_valid  output  1  result register holds an unconsumed result.
REQ-010 Port: rsp_ready  input  1  consumer accepts result when rsp_valid & rsp_ready.
REQ-011 Port: rsp_sum  output  32  registered sum.
REQ-012 Port: rsp_co  output  1  registered carry-out.
REQ-013 Port: rsp_id  output  2  index of requester owning the result.

Function
REQ-014 Block SHALL share one carryselect32 instance among all requesters; c_0 tied 0, c_1 tied 1.
REQ-015 FSM SHALL have states EMPTY (no result held) and FULL (rsp_valid=1).
REQ-016 Grant SHALL be allowed in a cycle iff some req bit is set and (state EMPTY or rsp_ready=1).
REQ-017 When allowed, exactly one ack bit SHALL assert combinationally that cycle, chosen round-robin.
REQ-018 Round-robin: search starts at index ptr; after grant to i, ptr <= (i+1) mod NREQ; ptr unchanged when no grant.
REQ-019 Granted operands SHALL drive the adder; on the same edge sum, co and id SHALL load the result register and state -> FULL.
REQ-020 Latency: rsp_valid SHALL rise the cycle after ack; back-to-back grants every cycle when rsp_ready stays 1.
REQ-021 FULL & rsp_ready=1 & no grant SHALL return to EMPTY; FULL & rsp_ready=0 SHALL hold all rsp_* outputs stable and suppress ack.
REQ-022 Simultaneous consume and grant SHALL stay FULL with the new result; no bubble.
REQ-023 Arithmetic SHALL be unsigned 32-bit modulo 2^32; carry-out reports bit 32.
REQ-024 req bits at index >= NREQ do not exist; a requester dropping req before ack SHALL simply not be granted.

Reset
REQ-025 While rst=1: ack=0, rsp_valid=0, rsp_sum=0, rsp_co=0, rsp_id=0, ptr=0, state EMPTY; any pending result is discarded.
REQ-026 First cycle after rst deasserts SHALL be grant-eligible, with requester 0 highest priority.

Configuration
REQ-027 Macro ADD_ARB_OVF_EN defined: extra output rsp_ovf (1 bit) SHALL carry registered two's-complement overflow (a[31]==b[31] and sum[31]!=a[31]), reset 0.
REQ-028 Macro undefined: port rsp_ovf and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-029 Include file add_arb_defs.vh SHALL hold DATA_W=32, ID_W=2, MAX_REQ=4 and the EMPTY/FULL state encodings.
REQ-030 Round-robin selection SHALL live in sub-module rr_arbiter (inputs req, ptr, enable; output one-hot grant and index).

Verification
REQ-031 Only req[0], a=5 b=10 ci=1, rsp_ready=1 -> ack[0] in cycle 0; cycle 1 rsp_valid=1, sum=16, co=0, id=0.
REQ-032 All four req set after reset, rsp_ready=1 -> acks 0,1,2,3 on consecutive cycles; results 37+48=85, 125+110+1=236, 63+211=274, 122+11+1=134 with matching ids.
REQ-033 rsp_ready=0 for 3 cycles while FULL with req[2] set -> no ack, rsp_sum/rsp_id unchanged; ack[2] the cycle rsp_ready returns 1.
REQ-034 a=0xFFFFFFFF b=1 ci=0 -> sum=0, co=1; with ADD_ARB_OVF_EN a=0x7FFFFFFF b=1 -> sum=0x80000000, ovf=1, co=0.
REQ-035 rst asserted while FULL with req[1] pending -> next cycle all outputs 0, no ack; after release req[1] granted with requester 0 idle.
